sawtooth_period_meter: RTL



---
 rtl/sawtooth_period_meter_pkg.sv | 24 ++
 rtl/sawtooth_period_meter_if.sv | 26 ++
 rtl/sawtooth_period_meter_flyback_detect.sv | 38 +++
 rtl/sawtooth_period_meter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sawtooth_period_meter_pkg.sv
// Shared types and constants for the sawtooth period meter.
package sawtooth_meter_pkg;

    localparam int unsigned DW         = 10;
    localparam int unsigned CW         = 16;
    localparam int unsigned DROP_TH    = 64;
    localparam int unsigned MIN_PERIOD = 4;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2
    } state_e;

    typedef struct packed {
        logic [CW-1:0] period;
        logic [DW-1:0] vmax;
        logic [DW-1:0] vmin;
        logic          timeout;
    } result_t;

endpackage

// File: rtl/sawtooth_period_meter_if.sv
// Sample input and result output bus of the sawtooth period meter.
interface sawtooth_period_meter_if;
    import sawtooth_meter_pkg::*;

    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] m_period;
    logic [DW-1:0] m_vmax;
    logic [DW-1:0] m_vmin;
    logic          m_timeout;
    logic          locked;
    logic          overrun;

    modport slave (
        input  s_valid, s_data, m_ready,
        output m_valid, m_period, m_vmax, m_vmin, m_timeout, locked, overrun
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  m_valid, m_period, m_vmax, m_vmin, m_timeout, locked, overrun
    );

endinterface

// File: rtl/sawtooth_period_meter_flyback_detect.sv
// Holds the last accepted sample and flags a large single-step fall (flyback).
module flyback_detect
    import sawtooth_meter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          fly_c
);

    logic [DW-1:0] prev_q, prev_d;
    logic [DW:0]   diff_c;

    always_comb begin
        prev_d = prev_q;
        if (clr) begin
            prev_d = '0;
        end else if (s_valid) begin
            prev_d = s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Extra bit keeps the subtraction from wrapping.
    assign diff_c = {1'b0, prev_q} - {1'b0, s_data};
    assign fly_c  = s_valid && !clr && (prev_q > s_data) &&
                    (diff_c >= (DW+1)'(DROP_TH));

endmodule

// File: rtl/sawtooth_period_meter.sv
// Per-cycle period / peak / trough measurement of an ADC-sampled sawtooth.
module sawtooth_period_meter
    import sawtooth_meter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    sawtooth_period_meter_if.slave bus
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] vmax_q, vmax_d;
    logic [DW-1:0] vmin_q, vmin_d;
    logic          locked_q, locked_d;
    logic          overrun_q, overrun_d;
    logic          m_valid_q, m_valid_d;
    result_t       res_q, res_d;

    logic          clr_c;
    logic          fly_c;
    logic          emit_c;
    result_t       emit_res_c;

    assign clr_c = !en || (state_q == IDLE);

    flyback_detect u_flyback_detect (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_c),
        .s_valid (bus.s_valid),
        .s_data  (bus.s_data),
        .fly_c   (fly_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = SYNC;
                SYNC:    if (fly_c) state_d = MEASURE;
                MEASURE: if (bus.s_valid && !fly_c && (cnt_q == CNT_MAX - CW'(1)))
                             state_d = SYNC;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        vmax_d     = vmax_q;
        vmin_d     = vmin_q;
        locked_d   = locked_q;
        overrun_d  = overrun_q;
        res_d      = res_q;
        m_valid_d  = m_valid_q && !bus.m_ready;
        emit_c     = 1'b0;
        emit_res_c = '0;

        if (clr_c) begin
            cnt_d     = '0;
            locked_d  = 1'b0;
            overrun_d = 1'b0;
        end else if (state_q == SYNC) begin
            if (fly_c) begin
                cnt_d  = CW'(1);
                vmax_d = bus.s_data;
                vmin_d = bus.s_data;
            end
        end else if (bus.s_valid) begin
            if (fly_c) begin
                // The flyback sample itself opens the next cycle.
                if (cnt_q >= CW'(MIN_PERIOD)) begin
                    emit_c     = 1'b1;
                    emit_res_c = '{period: cnt_q, vmax: vmax_q, vmin: vmin_q, timeout: 1'b0};
                    locked_d   = 1'b1;
                end
                cnt_d  = CW'(1);
                vmax_d = bus.s_data;
                vmin_d = bus.s_data;
            end else begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                vmax_d = (bus.s_data > vmax_q) ? bus.s_data : vmax_q;
                vmin_d = (bus.s_data < vmin_q) ? bus.s_data : vmin_q;
                if (cnt_d == CNT_MAX) begin
                    emit_c     = 1'b1;
                    emit_res_c = '{period: CNT_MAX, vmax: vmax_d, vmin: vmin_d, timeout: 1'b1};
                    locked_d   = 1'b0;
                end
            end
        end

        // One-deep output: a full, unaccepted register drops the new result.
        if (emit_c) begin
            if (m_valid_q && !bus.m_ready) begin
                overrun_d = 1'b1;
            end else begin
                res_d     = emit_res_c;
                m_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            vmax_q    <= '0;
            vmin_q    <= '0;
            locked_q  <= 1'b0;
            overrun_q <= 1'b0;
            m_valid_q <= 1'b0;
            res_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            vmax_q    <= vmax_d;
            vmin_q    <= vmin_d;
            locked_q  <= locked_d;
            overrun_q <= overrun_d;
            m_valid_q <= m_valid_d;
            res_q     <= res_d;
        end
    end

    assign bus.m_valid   = m_valid_q;
    assign bus.m_period  = res_q.period;
    assign bus.m_vmax    = res_q.vmax;
    assign bus.m_vmin    = res_q.vmin;
    assign bus.m_timeout = res_q.timeout;
    assign bus.locked    = locked_q;
    assign bus.overrun   = overrun_q;

endmodule
